// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and sizes for the four-way AS5600 angle-read arbiter.
// One I2C master is time-shared across four encoder buses.
package i2c_bus_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int ANGLE_W = 12;
    localparam int TMO_W   = 20;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [ANGLE_W-1:0] data;
        logic               err;
    } rsp_t;

endpackage

// File: rtl/i2c_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// With no request, gnt_onehot is zero and gnt_idx echoes ptr.
module rr_arbiter
    import i2c_bus_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = ptr;
        found      = 1'b0;
        idx        = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            // IDX_W-bit add wraps modulo NUM_REQ
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Grants the shared I2C master to one requester at a time, settles the SCL/SDA mux,
// runs one read with a timeout and returns the result to the owner.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [ANGLE_W-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic [IDX_W-1:0]   mux_sel,
    output logic               i2c_start,
    output logic               i2c_abort,
    input  logic               i2c_done,
    input  logic               i2c_error,
    input  logic [ANGLE_W-1:0] i2c_data
);

    localparam logic [TMO_W-1:0] SETTLE_LAST = TMO_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_nx;
    logic [TMO_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    rsp_t               rsp_q;

    rr_arbiter u_rr (
        .req        (req),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    // One counter serves both the settle delay and the read timeout
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        i2c_start = 1'b0;
        i2c_abort = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = (SETTLE_CYCLES > 0) ? SETTLE : START;
                    cnt_nx   = '0;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nx = START;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            START: begin
                i2c_start = 1'b1;
                cnt_nx    = '0;
                state_nx  = WAIT;
            end
            WAIT: begin
                // A done landing on the last timeout cycle wins over the abort
                if (i2c_done) begin
                    state_nx = RESP;
                end else if (cnt == TMO_LAST) begin
                    i2c_abort = 1'b1;
                    state_nx  = RESP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rr_ptr  <= '0;
            grant   <= '0;
            mux_sel <= '0;
            rsp_q   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && |req) begin
                grant   <= arb_onehot;
                mux_sel <= arb_idx;
            end
            if (state == WAIT) begin
                if (i2c_done)
                    rsp_q <= '{data: i2c_data, err: i2c_error};
                else if (i2c_abort)
                    rsp_q <= '{data: '0, err: 1'b1};
            end
            if (state == RESP) begin
                grant  <= '0;
                rr_ptr <= mux_sel + IDX_W'(1);
            end
        end
    end

    assign rsp_valid = (state == RESP) ? grant : '0;
    assign rsp_data  = rsp_q.data;
    assign rsp_err   = rsp_q.err;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboarded bench: expected responses are queued when the master reply is driven
// and compared when rsp_valid fires.
module tb_i2c_bus_arbiter;

    localparam int SETTLE = 8;
    localparam int TMO    = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  grant, rsp_valid;
    logic [11:0] rsp_data;
    logic        rsp_err, busy, i2c_start, i2c_abort;
    logic [1:0]  mux_sel;
    logic        i2c_done = 1'b0;
    logic        i2c_error = 1'b0;
    logic [11:0] i2c_data = '0;

    typedef struct {
        logic [3:0]  gnt;
        logic [11:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [11:0] last_data = '0;
    logic        last_err = 1'b0;

    i2c_bus_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mux_sel   (mux_sel),
        .i2c_start (i2c_start),
        .i2c_abort (i2c_abort),
        .i2c_done  (i2c_done),
        .i2c_error (i2c_error),
        .i2c_data  (i2c_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        idx_of = 2'd0;
        for (int i = 0; i < 4; i++)
            if (oh[i]) idx_of = 2'(i);
    endfunction

    always @(negedge clock) begin
        if (!reset && rsp_valid != 4'b0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {28'b0, rsp_valid}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid", {28'b0, rsp_valid}, {28'b0, mon_e.gnt});
                chk("rsp_data", {20'b0, rsp_data}, {20'b0, mon_e.data});
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
            end
        end
    end

    // mode: 0 done in WAIT, 1 timeout, 2 done on final timeout cycle, 3 reset in WAIT
    task automatic run_txn(input logic [3:0] reqv, input logic [3:0] exp_g, input int mode,
                           input logic [11:0] d, input logic e, input bit drop, input bit glitch);
        int k;
        int n_ab;
        req = reqv;
        @(negedge clock);
        chk("grant", {28'b0, grant}, {28'b0, exp_g});
        chk("mux_sel", {30'b0, mux_sel}, {30'b0, idx_of(exp_g)});
        chk("busy", {31'b0, busy}, 32'h1);
        k = 0;
        while (!i2c_start && k < 200) begin
            if (glitch && k == 3) begin
                i2c_done = 1'b1; i2c_data = 12'hFFF; i2c_error = 1'b1;
            end else begin
                i2c_done = 1'b0;
            end
            @(negedge clock);
            k++;
        end
        i2c_done = 1'b0;
        chk("start_lat", k, SETTLE);
        chk("grant_hold", {28'b0, grant}, {28'b0, exp_g});
        if (glitch) begin
            chk("glitch_data", {20'b0, rsp_data}, {20'b0, last_data});
            chk("glitch_err", {31'b0, rsp_err}, {31'b0, last_err});
        end
        case (mode)
            0: begin
                repeat (3) @(negedge clock);
                i2c_done = 1'b1; i2c_data = d; i2c_error = e;
                sb.push_back('{gnt: exp_g, data: d, err: e});
                last_data = d; last_err = e;
                @(negedge clock);
                i2c_done = 1'b0;
                chk("rsp_lat", {28'b0, rsp_valid}, {28'b0, exp_g});
            end
            1: begin
                sb.push_back('{gnt: exp_g, data: 12'h0, err: 1'b1});
                last_data = '0; last_err = 1'b1;
                k = 0;
                while (!i2c_abort && k < 200) begin
                    @(negedge clock);
                    k++;
                end
                chk("abort_lat", k, TMO);
                @(negedge clock);
                chk("rsp_lat", {28'b0, rsp_valid}, {28'b0, exp_g});
            end
            2: begin
                n_ab = 0;
                for (int j = 1; j <= TMO; j++) begin
                    @(negedge clock);
                    if (j == TMO) begin
                        i2c_done = 1'b1; i2c_data = d; i2c_error = e;
                        sb.push_back('{gnt: exp_g, data: d, err: e});
                        last_data = d; last_err = e;
                    end
                    #1;
                    if (i2c_abort) n_ab++;
                end
                chk("abort_none", n_ab, 0);
                @(negedge clock);
                i2c_done = 1'b0;
                chk("rsp_lat", {28'b0, rsp_valid}, {28'b0, exp_g});
            end
            default: begin
                @(negedge clock);
                chk("wait_busy", {31'b0, busy}, 32'h1);
                reset = 1'b1;
                #1;
                chk("rst_grant", {28'b0, grant}, 32'h0);
                chk("rst_busy", {31'b0, busy}, 32'h0);
                chk("rst_abort", {31'b0, i2c_abort}, 32'h0);
                chk("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
                chk("rst_mux_sel", {30'b0, mux_sel}, 32'h0);
                chk("rst_data", {20'b0, rsp_data}, 32'h0);
                chk("rst_err", {31'b0, rsp_err}, 32'h0);
                last_data = '0; last_err = 1'b0;
                req = '0;
                @(negedge clock);
                chk("rst_abort_hold", {31'b0, i2c_abort}, 32'h0);
                reset = 1'b0;
                return;
            end
        endcase
        if (drop) req = '0;
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("init_grant", {28'b0, grant}, 32'h0);
        chk("init_busy", {31'b0, busy}, 32'h0);
        chk("init_mux", {30'b0, mux_sel}, 32'h0);
        chk("init_data", {20'b0, rsp_data}, 32'h0);
        chk("init_start", {31'b0, i2c_start}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // fairness with all four requesting continuously
        for (int i = 0; i < 4; i++)
            run_txn(4'hF, 4'(1 << i), 0, 12'(12'h100 + i), 1'b0, i == 3, 1'b0);
        run_txn(4'b0001, 4'b0001, 0, 12'h5A3, 1'b0, 1'b1, 1'b0);
        run_txn(4'b0010, 4'b0010, 1, 12'h000, 1'b0, 1'b1, 1'b0);
        run_txn(4'b0001, 4'b0001, 2, 12'h3C7, 1'b1, 1'b1, 1'b0);

        // spurious done while idle
        i2c_done = 1'b1; i2c_data = 12'hFFF; i2c_error = 1'b0;
        @(negedge clock);
        i2c_done = 1'b0;
        @(negedge clock);
        chk("idle_busy", {31'b0, busy}, 32'h0);
        chk("idle_data", {20'b0, rsp_data}, {20'b0, last_data});
        chk("idle_err", {31'b0, rsp_err}, {31'b0, last_err});

        run_txn(4'b1000, 4'b1000, 0, 12'h0AB, 1'b0, 1'b1, 1'b1);
        run_txn(4'b0100, 4'b0100, 3, 12'h000, 1'b0, 1'b1, 1'b0);
        run_txn(4'b0110, 4'b0010, 0, 12'h123, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: cycles mux_sel is held stable before i2c_start.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum cycles waited for i2c_done, 20-bit range.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-004 clock  in  1  main clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 req  in  4  per-requester level request for one AS5600 angle read.
REQ-007 grant  out  4  one-hot owner of the shared I2C master; 0 when idle.
REQ-008 rsp_valid  out  4  one-cycle pulse to the owning requester at transaction end.
REQ-009 rsp_data  out  12  raw angle returned, shared by all requesters.
REQ-010 rsp_err  out  1  qualifies rsp_data; 1 = I2C error or timeout.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 mux_sel  out  2  selects which encoder bus the SCL/SDA mux routes to the master.
REQ-013 i2c_start  out  1  one-cycle pulse starting a read on the master.
REQ-014 i2c_abort  out  1  one-cycle pulse forcing the master back to idle.
REQ-015 i2c_done  in  1  one-cycle pulse: master read complete.
REQ-016 i2c_error  in  1  valid with i2c_done: NACK or bus error.
REQ-017 i2c_data  in  12  raw angle, valid with i2c_done.

Function
REQ-018 The FSM SHALL have the states IDLE, SETTLE, START, WAIT and RESP.
REQ-019 In IDLE with req!=0, the FSM SHALL pick a winner round-robin, searching from rr_ptr upward mod 4, and register grant and mux_sel at the next edge.
- With SETTLE_CYCLES>0, the next state SHALL be SETTLE.
- With SETTLE_CYCLES=0, the next state SHALL be START.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to START.
REQ-021 START SHALL assert i2c_start for one cycle, clear the timeout counter, and go to WAIT.
REQ-022 On i2c_done in WAIT, the FSM SHALL latch rsp_data=i2c_data and rsp_err=i2c_error, then go to RESP.
REQ-023 WAIT SHALL increment the timeout counter each cycle.
- When the counter reaches TIMEOUT_CYCLES-1 without i2c_done, the FSM SHALL pulse i2c_abort and go to RESP.
- The timeout response SHALL be rsp_err=1 and rsp_data=0.
REQ-024 If i2c_done arrives in the same cycle as the timeout, i2c_done SHALL take priority and no abort is issued.
REQ-025 RESP SHALL, for one cycle:
- pulse rsp_valid[g] for the granted requester g;
- clear grant at the next edge;
- set rr_ptr=(g+1) mod 4;
- go to IDLE.
REQ-026 rsp_data and rsp_err SHALL hold their values until the next RESP.
REQ-027 mux_sel SHALL hold its value in IDLE and change only on grant.
REQ-028 A requester SHALL hold req until it samples rsp_valid, and SHALL deassert req on that edge.
- If req is still high afterwards, it re-enters arbitration normally.
REQ-029 If req[g] drops mid-transaction, the transaction SHALL complete and rsp_valid[g] still pulses; there is no early abort.
REQ-030 i2c_done or i2c_error in any state other than WAIT SHALL be ignored.
REQ-031 At most one grant bit SHALL be high at any time, and grant SHALL be stable from SETTLE through RESP.
REQ-032 Latency: with req sampled in IDLE at cycle T, i2c_start SHALL occur at T+1+SETTLE_CYCLES, and rsp_valid at one cycle after i2c_done.

Reset
REQ-033 Reset SHALL asynchronously force:
- the FSM to IDLE and rr_ptr=0;
- grant=0, rsp_valid=0, rsp_data=0, rsp_err=0;
- busy=0, mux_sel=0, i2c_start=0, i2c_abort=0;
- the settle and timeout counters to 0.
REQ-034 Reset mid-transaction SHALL NOT pulse i2c_abort, because the master shares the same reset.
REQ-035 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-036 A shared package SHALL hold:
- the FSM state enum (IDLE/SETTLE/START/WAIT/RESP);
- NUM_REQ=4 and ANGLE_W=12;
- the timeout counter width of 20.
REQ-037 Round-robin selection SHALL live in a sub-module rr_arbiter with inputs req[3:0] and ptr[1:0], and outputs gnt_onehot[3:0] and gnt_idx[1:0].
- rr_arbiter SHALL be combinational.
- rr_ptr SHALL be registered in i2c_bus_arbiter.
REQ-038 The settle counter and timeout counter SHALL be one shared counter, reused across states.

Verification
REQ-039 Single request, SETTLE_CYCLES=8: req=0001 at T -> grant=0001 and mux_sel=0 at T+1, i2c_start at T+9; i2c_done with data 0x5A3 -> rsp_valid=0001, rsp_data=0x5A3, rsp_err=0.
REQ-040 Fairness: req=1111 held through four transactions -> grants in the order 0001, 0010, 0100, 1000, with rr_ptr wrapping to 0.
REQ-041 Timeout, TIMEOUT_CYCLES=16, no i2c_done -> i2c_abort pulses 16 cycles after i2c_start exits to WAIT; rsp_err=1, rsp_data=0.
REQ-042 i2c_done coincident with the final timeout cycle -> no i2c_abort, rsp_err=i2c_error, data latched.
REQ-043 Reset asserted in WAIT with grant=0100 -> all outputs 0 immediately with no abort pulse; after release, req=0110 grants 0010.
REQ-044 i2c_done pulsed in IDLE and in SETTLE -> ignored: no rsp_valid, and rsp_data unchanged.
